// File: rtl/rf_wb_queue.sv
// Write-back queue for the 32x32 register file: merges results from two producers
// into an in-order FIFO and retires one register-file write per cycle.
module rf_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [AW-1:0]            a_addr,
    input  logic [DW-1:0]            a_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [AW-1:0]            b_addr,
    input  logic [DW-1:0]            b_data,
    input  logic                     wr_stall,
    output logic                     wr_en,
    output logic [AW-1:0]            wr_addr,
    output logic [DW-1:0]            wr_data,
    output logic [31:0]              pend_mask,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             r_fav_b;

    logic [CW-1:0]    w_free;
    logic             w_a_ready;
    logic             w_b_ready;
    logic             w_a_hs;
    logic             w_b_hs;
    logic             w_push_a;
    logic             w_push_b;
    logic             w_fav_push;
    logic             w_pop;
    logic [CW-1:0]    w_n_push;
    logic [PW-1:0]    w_slot_fav;
    logic [PW-1:0]    w_slot_oth;
    logic [PW-1:0]    w_slot_a;
    logic [PW-1:0]    w_slot_b;
    logic [31:0]      w_pend;

    // Free space uses the registered count only; a same-cycle pop is not credited.
    always_comb begin
        w_free    = CW'(DEPTH) - r_count;
        w_a_ready = 1'b0;
        w_b_ready = 1'b0;
        if (nrst) begin
            if (w_free >= CW'(2)) begin
                w_a_ready = 1'b1;
                w_b_ready = 1'b1;
            end else if (w_free == CW'(1)) begin
                if (r_fav_b) begin
                    w_b_ready = 1'b1;
                    w_a_ready = !b_valid;
                end else begin
                    w_a_ready = 1'b1;
                    w_b_ready = !a_valid;
                end
            end
        end
    end

    assign w_a_hs     = a_valid & w_a_ready;
    assign w_b_hs     = b_valid & w_b_ready;
    assign w_push_a   = w_a_hs & (a_addr != '0);
    assign w_push_b   = w_b_hs & (b_addr != '0);
    assign w_fav_push = r_fav_b ? w_push_b : w_push_a;
    assign w_n_push   = CW'(w_push_a) + CW'(w_push_b);
    assign w_pop      = nrst & (r_count != '0) & !wr_stall;

    // Favoured entry takes the lower slot; the other lands after it when both push.
    assign w_slot_fav = r_wr_ptr;
    assign w_slot_oth = r_wr_ptr + PW'(w_fav_push);
    assign w_slot_a   = r_fav_b ? w_slot_oth : w_slot_fav;
    assign w_slot_b   = r_fav_b ? w_slot_fav : w_slot_oth;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
            r_fav_b  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + PW'(1);
            end
            if (w_push_a) r_vld[w_slot_a] <= 1'b1;
            if (w_push_b) r_vld[w_slot_b] <= 1'b1;
            r_wr_ptr <= r_wr_ptr + PW'(w_n_push);
            r_count  <= r_count + w_n_push - CW'(w_pop);
            if (r_fav_b ? w_b_hs : w_a_hs) r_fav_b <= !r_fav_b;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_a) begin
            r_addr[w_slot_a] <= a_addr;
            r_data[w_slot_a] <= a_data;
        end
        if (w_push_b) begin
            r_addr[w_slot_b] <= b_addr;
            r_data[w_slot_b] <= b_data;
        end
    end

    always_comb begin
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i]) w_pend[r_addr[i]] = 1'b1;
        end
    end

    assign a_ready   = w_a_ready;
    assign b_ready   = w_b_ready;
    assign wr_en     = w_pop;
    assign wr_addr   = w_pop ? r_addr[r_rd_ptr] : '0;
    assign wr_data   = w_pop ? r_data[r_rd_ptr] : '0;
    assign pend_mask = nrst ? (w_pend & ~32'h1) : '0;
    assign count     = r_count;
    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);

endmodule
